// File: rtl/bitwise_logic_engine.sv
// ---------------------------------------------------------------------------
// bitwise_logic_engine
//   Multi-cycle WIDTH-bit bitwise logic unit. A request (in_op, x, y) is
//   latched on a valid/ready handshake. The result is then built SLICE bits
//   per clock, LSB slice first. The completed word is returned with a zero
//   flag on a valid/ready response interface.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   request valid
//     in_ready   engine idle and able to accept a request
//     in_op      operation select (see bitwise_logic_slice)
//     x, y       operands
//     out_valid  result valid (held until out_ready)
//     out_ready  consumer accepts the result
//     out        registered result, changes only on entry to DONE or reset
//     zero_flag  registered, out == 0 (meaningful while out_valid)
//     busy       high while computing or holding a result
//
//   SLICE must divide WIDTH evenly; K = WIDTH/SLICE cycles per operation.
// ---------------------------------------------------------------------------

// Per-slice evaluator: one instance per SLICE-bit lane of the operands.
module bitwise_logic_slice #(
   parameter int SLICE = 4
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] r
);
   always_comb begin
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a & b);
         3'b100:  r = ~(a | b);
         3'b101:  r = ~(a ^ b);
         3'b110:  r = ~a;
         default: r = a & ~b;
      endcase
   end
endmodule

module bitwise_logic_engine #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero_flag,
   output logic             busy
);
   localparam int K  = WIDTH / SLICE;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state;
   logic [CW-1:0]             cnt;
   logic [2:0]                op_q;
   logic [K-1:0][SLICE-1:0]   x_q, y_q;
   logic [K-1:0][SLICE-1:0]   work, work_nxt, res;

   // Every lane evaluates continuously on the latched operands; only the
   // lane selected by cnt is committed to the working register each cycle.
   // The lanes are kept separate so the slice select is a simple compare
   // per lane rather than a variable part-select.
   for (genvar g = 0; g < K; g++) begin : g_lane
      bitwise_logic_slice #(.SLICE(SLICE)) u_slice (
         .op (op_q),
         .a  (x_q[g]),
         .b  (y_q[g]),
         .r  (res[g])
      );
      assign work_nxt[g] = (cnt == CW'(g)) ? res[g] : work[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         op_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         work      <= '0;
         out       <= '0;
         zero_flag <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q     <= in_op;
                  x_q      <= x;
                  y_q      <= y;
                  cnt      <= '0;
                  work     <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               work <= work_nxt;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // work_nxt already holds the final slice.
                  out       <= work_nxt;
                  zero_flag <= (work_nxt == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // A request presented alongside the response handshake is
               // not taken; in_ready only rises in the following cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bitwise_logic_engine.sv
module tb_bitwise_logic_engine;
   logic        clk = 1'b0;
   logic        rst_n, rst_p_n;
   logic        in_valid, out_ready;
   logic [2:0]  in_op;
   logic [15:0] x, y;

   logic        in_ready, out_valid, zero_flag, busy;
   logic [15:0] out;
   logic        p16_in_ready, p16_out_valid, p16_zero_flag, p16_busy;
   logic [15:0] p16_out;
   logic        p1_in_ready, p1_out_valid, p1_zero_flag, p1_busy;
   logic [15:0] p1_out;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   bitwise_logic_engine #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .zero_flag(zero_flag), .busy(busy));

   bitwise_logic_engine #(.WIDTH(16), .SLICE(16)) dut_p16 (
      .clk(clk), .rst_n(rst_p_n), .in_valid(in_valid), .in_ready(p16_in_ready),
      .in_op(in_op), .x(x), .y(y), .out_valid(p16_out_valid), .out_ready(out_ready),
      .out(p16_out), .zero_flag(p16_zero_flag), .busy(p16_busy));

   bitwise_logic_engine #(.WIDTH(16), .SLICE(1)) dut_p1 (
      .clk(clk), .rst_n(rst_p_n), .in_valid(in_valid), .in_ready(p1_in_ready),
      .in_op(in_op), .x(x), .y(y), .out_valid(p1_out_valid), .out_ready(out_ready),
      .out(p1_out), .zero_flag(p1_zero_flag), .busy(p1_busy));

   // Word-level reference: the whole result at once, no slicing.
   function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return a & ~b;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One full transaction on the SLICE=4 engine with out_ready high.
   // Operands, opcode and in_valid are scrambled during RUN, and in_valid is
   // raised together with the response handshake to show it is not taken.
   task automatic do_op(input string nm, input logic [2:0] op,
                        input logic [15:0] a, b, eo, input logic ez);
      int   lat;
      logic rdy_low;
      @(negedge clk);
      chk({nm, ".in_ready_pre"}, in_ready, 1);
      in_valid = 1; in_op = op; x = a; y = b; out_ready = 1;
      @(negedge clk);
      in_valid = 0; lat = 0; rdy_low = 1;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_low = 0;
         x = 16'($urandom); y = 16'($urandom);
         in_op = 3'($urandom_range(0, 7)); in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      chk({nm, ".latency"}, lat, 4);
      chk({nm, ".ready_low_run"}, rdy_low, 1);
      chk({nm, ".out"}, out, eo);
      chk({nm, ".zero_flag"}, zero_flag, ez);
      chk({nm, ".ready_done"}, in_ready, 0);
      chk({nm, ".busy_done"}, busy, 1);
      in_valid = 1; x = 16'hFFFF; in_op = 3'd1;
      @(negedge clk);
      chk({nm, ".valid_drop"}, out_valid, 0);
      chk({nm, ".ready_back"}, in_ready, 1);
      chk({nm, ".busy_idle"}, busy, 0);
      chk({nm, ".out_hold"}, out, eo);
      in_valid = 0;
   endtask

   typedef struct {
      string       nm;
      logic [2:0]  op;
      logic [15:0] a, b, eo;
      logic        ez;
   } vec_t;

   initial begin
      vec_t vt[5];
      int   lat;
      logic [15:0] e, ra, rb;
      logic [2:0]  rop;
      int   l16, l1;
      logic [15:0] o16, o1;
      logic z16, z1;

      vt[0] = '{"and",  3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
      vt[1] = '{"xorz", 3'b010, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
      vt[2] = '{"notx", 3'b110, 16'h00FF, 16'h1234, 16'hFF00, 1'b0};
      vt[3] = '{"nand", 3'b011, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
      vt[4] = '{"nor",  3'b100, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};

      rst_n = 0; rst_p_n = 0; in_valid = 0; out_ready = 0;
      in_op = 0; x = 0; y = 0;
      #12;
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.out", out, 0);
      chk("rst.zero_flag", zero_flag, 0);
      chk("rst.busy", busy, 0);
      @(negedge clk); rst_n = 1;

      foreach (vt[i]) do_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].eo, vt[i].ez);

      // Backpressure: result must hold while out_ready is low.
      @(negedge clk);
      chk("bp.in_ready_pre", in_ready, 1);
      in_valid = 1; in_op = 3'b111; x = 16'h1234; y = 16'h00FF; out_ready = 0;
      @(negedge clk);
      in_valid = 0; lat = 0;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("bp.latency", lat, 4);
      for (int i = 0; i < 6; i++) begin
         chk("bp.out", out, 16'h1200);
         chk("bp.out_valid", out_valid, 1);
         chk("bp.in_ready", in_ready, 0);
         in_valid = (i == 2); x = 16'hFFFF; in_op = 3'b000;
         @(negedge clk);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("bp.valid_drop", out_valid, 0);
      chk("bp.ready_back", in_ready, 1);
      chk("bp.out_hold", out, 16'h1200);

      // Reset two cycles after acceptance.
      in_valid = 1; in_op = 3'b001; x = 16'h0F00; y = 16'h00F0;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("mid.busy_before", busy, 1);
      rst_n = 0;
      #1;
      chk("mid.out", out, 0);
      chk("mid.out_valid", out_valid, 0);
      chk("mid.in_ready", in_ready, 1);
      chk("mid.busy", busy, 0);
      chk("mid.zero_flag", zero_flag, 0);
      @(negedge clk); rst_n = 1;
      do_op("mid.retry", 3'b001, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0);

      // K=1 and K=16 engines, same request, run alongside the default one.
      @(negedge clk); rst_p_n = 1;
      @(negedge clk);
      in_valid = 1; in_op = 3'b101; x = 16'h5A5A; y = 16'hA5A5; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      l16 = -1; l1 = -1; o16 = 16'hDEAD; o1 = 16'hDEAD; z16 = 0; z1 = 0;
      for (int t = 0; t <= 24; t++) begin
         if (p16_out_valid && l16 < 0) begin l16 = t; o16 = p16_out; z16 = p16_zero_flag; end
         if (p1_out_valid && l1 < 0) begin l1 = t; o1 = p1_out; z1 = p1_zero_flag; end
         @(negedge clk);
      end
      chk("k1.latency", l16, 1);
      chk("k1.out", o16, 16'h0000);
      chk("k1.zero_flag", z16, 1);
      chk("k16.latency", l1, 16);
      chk("k16.out", o1, 16'h0000);
      chk("k16.zero_flag", z1, 1);
      chk("k4.out", out, 16'h0000);
      chk("k4.in_ready", in_ready, 1);
      rst_p_n = 0;

      // Random requests against the word-level model.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (i % 8 == 0) rb = (rop == 3'd2) ? ra : rb;
         e = ref_op(rop, ra, rb);
         do_op("rand", rop, ra, rb, e, (e == 16'h0));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
